// File: rtl/note_glyph_scheduler_if.sv
// Bundle between game logic / pixel generator and the note glyph scheduler:
// spawn handshake, frame tick, pixel query and hit reporting.
interface note_glyph_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 frameTick;
    logic                 spawnReq;
    logic [3:0]           spawnKey;
    logic                 spawnSide;
    logic [7:0]           spawnColor;
    logic                 spawnAck;
    logic [9:0]           hCount;
    logic [9:0]           vCount;
    logic                 InGlyphNote0;
    logic [7:0]           RGBNote0;
    logic                 noteHitValid;
    logic [3:0]           noteHitKey;
    logic                 noteHitSide;
    logic [NUM_SLOTS-1:0] activeMask;

    modport master (
        output frameTick, spawnReq, spawnKey, spawnSide, spawnColor, hCount, vCount,
        input  spawnAck, InGlyphNote0, RGBNote0, noteHitValid, noteHitKey, noteHitSide, activeMask
    );

    modport slave (
        input  frameTick, spawnReq, spawnKey, spawnSide, spawnColor, hCount, vCount,
        output spawnAck, InGlyphNote0, RGBNote0, noteHitValid, noteHitKey, noteHitSide, activeMask
    );
endinterface

// File: rtl/note_glyph_scheduler.sv
// Falling-note glyph slots: spawn handshake, per-frame movement toward the hit
// lines with hit reporting, and a one-cycle registered per-pixel overlay lookup.
module note_glyph_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SPEED     = 2,
    parameter int SPAWN_X   = 313
) (
    input  logic                  pixelClk,
    input  logic                  reset,
    note_glyph_scheduler_if.slave bus
);
    localparam int              IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [9:0]      LEFT_HIT  = 10'd95;
    localparam logic [9:0]      RIGHT_HIT = 10'd532;
    localparam logic [9:0]      STEP      = 10'(SPEED);

    typedef enum logic {IDLE, UPDATE} state_t;
    state_t           state, stateNext;
    logic [IDX_W-1:0] idx, idxNext;

    logic [NUM_SLOTS-1:0] slotValid;
    logic [NUM_SLOTS-1:0] slotSide;
    logic [9:0]           slotX     [NUM_SLOTS];
    logic [3:0]           slotKey   [NUM_SLOTS];
    logic [7:0]           slotColor [NUM_SLOTS];

    logic       spawnAckR, hitValidR, hitSideR, inGlyphR;
    logic [3:0] hitKeyR;
    logic [7:0] rgbR;

    logic             freeFound;
    logic [IDX_W-1:0] freeIdx;
    logic             spawnAccept, spawnAlloc, updValid, updHit;
    logic [9:0]       updX;
    logic             pixHit;
    logic [7:0]       pixColor;

    // 14x14 box at x..x+13, centred in the 30-px key row (rows key*30+8 .. +21)
    function automatic logic inGlyph(input logic [9:0] x, input logic [3:0] key,
                                     input logic [9:0] h, input logic [9:0] v);
        logic [10:0] top;
        top = 11'(key) * 11'd30 + 11'd8;
        return ({1'b0, h} >= {1'b0, x}) && ({1'b0, h} <= {1'b0, x} + 11'd13) &&
               ({1'b0, v} >= top) && ({1'b0, v} <= top + 11'd13);
    endfunction

    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slotValid[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        spawnAccept = 1'b0;
        spawnAlloc  = 1'b0;
        updValid    = 1'b0;
        updHit      = 1'b0;
        updX        = slotX[idx];
        case (state)
            IDLE: begin
                // The !spawnAckR guard stops a still-high request being taken twice
                if (bus.spawnReq && !spawnAckR) begin
                    if (bus.spawnKey > 4'd13) begin
                        spawnAccept = 1'b1;
                    end else if (freeFound) begin
                        spawnAccept = 1'b1;
                        spawnAlloc  = 1'b1;
                    end
                end
                if (bus.frameTick) begin
                    stateNext = UPDATE;
                    idxNext   = '0;
                end
            end
            UPDATE: begin
                updValid = slotValid[idx];
                if (slotSide[idx]) begin
                    updX   = slotX[idx] + STEP;
                    updHit = updValid && (updX >= RIGHT_HIT);
                end else begin
                    updX   = slotX[idx] - STEP;
                    updHit = updValid && (updX <= LEFT_HIT);
                end
                if (idx == LAST_IDX) begin
                    stateNext = IDLE;
                    idxNext   = '0;
                end else begin
                    idxNext = idx + IDX_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            slotValid <= '0;
            spawnAckR <= 1'b0;
            hitValidR <= 1'b0;
            hitKeyR   <= '0;
            hitSideR  <= 1'b0;
        end else begin
            spawnAckR <= spawnAccept;
            hitValidR <= updHit;
            if (updHit) begin
                hitKeyR         <= slotKey[idx];
                hitSideR        <= slotSide[idx];
                slotValid[idx]  <= 1'b0;
            end
            if (spawnAlloc) slotValid[freeIdx] <= 1'b1;
        end
    end

    // Slot payload needs no reset: it is ignored whenever the valid bit is clear
    always_ff @(posedge pixelClk) begin
        if (spawnAlloc) begin
            slotX[freeIdx]     <= 10'(SPAWN_X);
            slotKey[freeIdx]   <= bus.spawnKey;
            slotSide[freeIdx]  <= bus.spawnSide;
            slotColor[freeIdx] <= bus.spawnColor;
        end else if (updValid && !updHit) begin
            slotX[idx] <= updX;
        end
    end

    always_comb begin
        pixHit   = 1'b0;
        pixColor = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slotValid[i] && inGlyph(slotX[i], slotKey[i], bus.hCount, bus.vCount)) begin
                pixHit   = 1'b1;
                pixColor = slotColor[i];
            end
        end
    end

    // Pixel stage boundary: one cycle of latency relative to hCount/vCount
    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            inGlyphR <= 1'b0;
            rgbR     <= '0;
        end else begin
            inGlyphR <= pixHit;
            rgbR     <= pixColor;
        end
    end

    assign bus.spawnAck     = spawnAckR;
    assign bus.noteHitValid = hitValidR;
    assign bus.noteHitKey   = hitKeyR;
    assign bus.noteHitSide  = hitSideR;
    assign bus.InGlyphNote0 = inGlyphR;
    assign bus.RGBNote0     = rgbR;
    assign bus.activeMask   = slotValid;
endmodule

// File: tb/tb_note_glyph_scheduler.sv
// Directed and randomized bench for note_glyph_scheduler against a frame-level
// model of the glyph slots.
module tb_note_glyph_scheduler;
    localparam int N       = 4;
    localparam int SPEED   = 2;
    localparam int SPAWN_X = 313;

    logic pixelClk = 1'b0;
    logic reset    = 1'b0;

    note_glyph_scheduler_if #(.NUM_SLOTS(N)) bus();

    note_glyph_scheduler #(.NUM_SLOTS(N), .SPEED(SPEED), .SPAWN_X(SPAWN_X)) dut (
        .pixelClk (pixelClk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 pixelClk = ~pixelClk;

    int nAsserts = 0;
    int nFail    = 0;

    bit mValid [N];
    int mX     [N];
    int mKey   [N];
    int mSide  [N];
    int mColor [N];
    int expKey [$];
    int expSide[$];
    bit pend;
    int pKey, pSide, pColor;
    logic [N-1:0] maskAtHit;
    int lastAckK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixelClk);
        #1;
    endtask

    function automatic int mMask();
        int m = 0;
        for (int i = 0; i < N; i++) if (mValid[i]) m |= (1 << i);
        return m;
    endfunction

    function automatic int mFree();
        for (int i = 0; i < N; i++) if (!mValid[i]) return i;
        return -1;
    endfunction

    // Returns 1 when the pending request is acknowledged now
    function automatic int mTrySpawn();
        int f;
        if (!pend) return 0;
        if (pKey > 13) begin
            pend = 0;
            return 1;
        end
        f = mFree();
        if (f < 0) return 0;
        mValid[f] = 1; mX[f] = SPAWN_X; mKey[f] = pKey; mSide[f] = pSide; mColor[f] = pColor;
        pend = 0;
        return 1;
    endfunction

    function automatic void mFrame();
        int nx;
        expKey.delete();
        expSide.delete();
        for (int i = 0; i < N; i++) begin
            if (mValid[i]) begin
                nx = (mSide[i] == 0) ? mX[i] - SPEED : mX[i] + SPEED;
                if ((mSide[i] == 0 && nx <= 95) || (mSide[i] == 1 && nx >= 532)) begin
                    mValid[i] = 0;
                    expKey.push_back(mKey[i]);
                    expSide.push_back(mSide[i]);
                end else begin
                    mX[i] = nx;
                end
            end
        end
    endfunction

    task automatic mPixel(input int h, input int v, output int inG, output int rgb);
        inG = 0;
        rgb = 0;
        for (int i = 0; i < N; i++) begin
            if (mValid[i] && h >= mX[i] && h <= mX[i] + 13 &&
                v >= mKey[i] * 30 + 8 && v <= mKey[i] * 30 + 21) begin
                inG = 1;
                rgb = mColor[i];
                return;
            end
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.frameTick = 0; bus.spawnReq = 0;
        #1;
        chk("rstSpawnAck", bus.spawnAck, 0);
        chk("rstHitValid", bus.noteHitValid, 0);
        chk("rstHitKey", bus.noteHitKey, 0);
        chk("rstHitSide", bus.noteHitSide, 0);
        chk("rstInGlyph", bus.InGlyphNote0, 0);
        chk("rstRgb", bus.RGBNote0, 0);
        chk("rstActiveMask", bus.activeMask, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) mValid[i] = 0;
        pend = 0;
    endtask

    task automatic spawn(input int key, input int side, input int color);
        int lat = 0;
        int expAck;
        bus.spawnKey = 4'(key); bus.spawnSide = side[0]; bus.spawnColor = 8'(color);
        bus.spawnReq = 1'b1;
        pend = 1; pKey = key; pSide = side; pColor = color;
        expAck = mTrySpawn();
        if (expAck == 1) begin
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (bus.spawnAck) begin
                    lat = k;
                    break;
                end
            end
            bus.spawnReq = 1'b0;
            chk("spawnAckLatency", lat, 1);
            tick();
            chk("spawnAckOnePulse", bus.spawnAck, 0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("spawnAckWhileFull", bus.spawnAck, 0);
            end
        end
        chk("activeMaskAfterSpawn", bus.activeMask, mMask());
    endtask

    task automatic runFrame(input bit spawnNow, input int sKey, input int sSide, input int sColor);
        int hits = 0;
        int acks = 0;
        int expAcks = 0;
        if (spawnNow) begin
            bus.spawnKey = 4'(sKey); bus.spawnSide = sSide[0]; bus.spawnColor = 8'(sColor);
            bus.spawnReq = 1'b1;
            pend = 1; pKey = sKey; pSide = sSide; pColor = sColor;
            expAcks += mTrySpawn();
        end
        mFrame();
        expAcks += mTrySpawn();
        bus.frameTick = 1'b1;
        for (int k = 0; k < N + 3; k++) begin
            tick();
            if (k == 0) bus.frameTick = 1'b0;
            if (bus.noteHitValid) begin
                if (hits < expKey.size()) begin
                    chk("hitKey", bus.noteHitKey, expKey[hits]);
                    chk("hitSide", bus.noteHitSide, expSide[hits]);
                end
                hits++;
                maskAtHit = bus.activeMask;
            end
            if (bus.spawnAck) begin
                acks++;
                lastAckK = k;
                bus.spawnReq = 1'b0;
            end
        end
        chk("hitCount", hits, expKey.size());
        chk("ackCount", acks, expAcks);
        chk("activeMaskAfterFrame", bus.activeMask, mMask());
    endtask

    task automatic probe(input int h, input int v);
        int inG, rgb;
        bus.hCount = 10'(h);
        bus.vCount = 10'(v);
        tick();
        mPixel(h, v, inG, rgb);
        chk("pixInGlyph", bus.InGlyphNote0, inG);
        chk("pixRgb", bus.RGBNote0, rgb);
    endtask

    task automatic probeExp(input int h, input int v, input int inG, input int rgb);
        bus.hCount = 10'(h);
        bus.vCount = 10'(v);
        tick();
        chk("pixDirectedIn", bus.InGlyphNote0, inG);
        chk("pixDirectedRgb", bus.RGBNote0, rgb);
    endtask

    initial begin
        bus.frameTick = 0; bus.spawnReq = 0; bus.spawnKey = 0; bus.spawnSide = 0;
        bus.spawnColor = 0; bus.hCount = 0; bus.vCount = 0;
        #3;
        doReset();

        // First glyph, pixel box and one-cycle latency
        spawn(3, 0, 8'hE0);
        chk("maskFirstSpawn", bus.activeMask, 4'b0001);
        probeExp(313, 98, 1, 8'hE0);
        probeExp(326, 111, 1, 8'hE0);
        probeExp(313, 97, 0, 0);
        probeExp(327, 98, 0, 0);
        probeExp(312, 105, 0, 0);

        // Fill remaining slots, then hold a fifth request
        spawn(7, 1, 8'h1C);
        spawn(1, 1, 8'h03);
        spawn(10, 1, 8'h55);
        chk("maskFull", bus.activeMask, 4'b1111);
        spawn(5, 0, 8'hA5);
        for (int f = 1; f <= 108; f++) runFrame(0, 0, 0, 0);
        probeExp(97, 98, 1, 8'hE0);
        probeExp(96, 98, 0, 0);
        probeExp(110, 98, 1, 8'hE0);
        probeExp(111, 98, 0, 0);
        runFrame(0, 0, 0, 0);
        chk("maskAtLeftHit", maskAtHit, 4'b1110);
        chk("pendingAckCycle", lastAckK, N + 1);
        probeExp(313, 158, 1, 8'hA5);
        runFrame(0, 0, 0, 0);
        chk("maskAfterRightHits", bus.activeMask, 4'b0001);

        // Overlap priority, discarded key, spawn coinciding with frameTick
        doReset();
        spawn(2, 0, 8'h1C);
        spawn(6, 1, 8'h77);
        spawn(2, 0, 8'h03);
        probeExp(320, 70, 1, 8'h1C);
        spawn(14, 0, 8'hFF);
        chk("maskAfterBadKey", bus.activeMask, 4'b0111);
        runFrame(1, 9, 0, 8'h3C);
        probeExp(311, 278, 1, 8'h3C);
        probeExp(310, 278, 0, 0);
        probeExp(311, 68, 1, 8'h1C);

        // Reset during UPDATE
        doReset();
        spawn(0, 0, 8'h11);
        spawn(4, 1, 8'h22);
        spawn(8, 0, 8'h33);
        bus.frameTick = 1'b1;
        tick();
        bus.frameTick = 1'b0;
        tick();
        doReset();
        runFrame(0, 0, 0, 0);

        // Randomized traffic against the model
        doReset();
        for (int it = 0; it < 400; it++) begin
            int r, key, slot;
            r = int'($urandom_range(0, 7));
            key = int'($urandom_range(0, 15));
            if (r <= 1) begin
                if (key > 13 || mFree() >= 0)
                    spawn(key, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end else if (r <= 5) begin
                runFrame(0, 0, 0, 0);
            end else if (r == 6) begin
                if (key > 13 || mFree() >= 0)
                    runFrame(1, key, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end else begin
                slot = int'($urandom_range(0, N - 1));
                if (mValid[slot])
                    probe(mX[slot] + int'($urandom_range(0, 15)) - 1,
                          mKey[slot] * 30 + 7 + int'($urandom_range(0, 15)));
                probe(int'($urandom_range(80, 560)), int'($urandom_range(0, 430)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
